trace_capture_buffer: RTL
=========================

Name: trace_capture_buffer

Overview:
- Debug-trace consumer that sits directly downstream of the MIPS_32 top-level core.
- Each cycle it samples the core's debug bus: instruction, ALU operand A, ALU operand B, write data and data-memory read data.
- Samples go into a circular buffer. Capture stops a programmable number of samples after an instruction-match trigger.
- The captured window is then drained oldest-first over a valid/ready stream, replacing free-running $monitor tracing in benches and on the board.

Parameters:
- DEPTH, 16, number of trace entries; power of two, ≥4.
- ADDR_W, 4, log2(DEPTH).
- POST_TRIG, 8, samples captured after the trigger sample; legal range 0..DEPTH-1.
- DATA_W, 32, width of each debug-bus field.

Ports:
- clk  in  1  rising-edge clock, shared with the core.
- rst  in  1  synchronous, active-low reset.
- arm  in  1  single-cycle pulse; starts capture from IDLE.
- trig_mask  in  DATA_W  bit mask applied to instruction for the trigger compare.
- trig_value  in  DATA_W  value the masked instruction is compared against.
- instruction  in  DATA_W  core debug bus.
- alu_a  in  DATA_W  core debug bus.
- alu_b  in  DATA_W  core debug bus.
- write_data  in  DATA_W  core debug bus.
- read_data_mem  in  DATA_W  core debug bus.
- rd_valid  out  1  readout entry valid.
- rd_ready  in  1  readout consumer ready.
- rd_data  out  5*DATA_W  entry, packed {instruction, alu_a, alu_b, write_data, read_data_mem}; instruction in the MSBs.
- rd_last  out  1  marks the final entry of the dump.
- state  out  2  current FSM state.
- count  out  ADDR_W+1  number of valid stored entries.
- triggered  out  1  sticky; set when the trigger fires.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, count=0, triggered=0, rd_valid=0, rd_last=0, rd_data=0, all pointers 0. Buffer contents are don't-care. Reset wins over every other event, including mid-capture and mid-dump.
- States and encoding: IDLE=0, ARMED=1, POST=2, DUMP=3.
- IDLE:
  - arm=1 → ARMED; wr_ptr, count, triggered and post counter cleared.
  - No capture happens on the arm cycle itself.
- ARMED:
  - Every edge writes the current bus into buf[wr_ptr], then wr_ptr+1 mod DEPTH.
  - count increments and saturates at DEPTH; when full, the oldest entry is overwritten.
  - Trigger condition: (instruction & trig_mask) == (trig_value & trig_mask), evaluated on the same cycle's inputs. The trigger sample is always stored.
  - On trigger: triggered←1, post counter←POST_TRIG, next state is POST, or DUMP if POST_TRIG=0.
- POST:
  - Captures each cycle as in ARMED and decrements the post counter.
  - When the counter reaches 0 after its last write → DUMP.
  - The trigger is not re-evaluated.
- DUMP:
  - rd_ptr = wr_ptr − count (mod DEPTH), i.e. the oldest entry; rd_valid=1; capture is frozen.
  - rd_data = buf[rd_ptr]. rd_data and rd_last are held stable while rd_valid & !rd_ready.
  - Each rd_valid & rd_ready handshake advances rd_ptr and decrements count.
  - rd_last=1 when count==1.
  - The handshake on rd_last → IDLE with rd_valid=0 on the next cycle.
  - triggered stays 1 until the next arm.
- arm is ignored in ARMED, POST and DUMP.
- No capture happens in IDLE or DUMP.
- Total latency from trigger edge to first rd_valid = POST_TRIG+1 cycles.
- Every sample is captured, duplicates included; no change-filtering.

Decomposition:
- Package trace_pkg holds:
  - state encoding constants;
  - TRACE_W = 5*DATA_W;
  - field offset constants for the packed entry (INSTR_LSB, ALUA_LSB, ALUB_LSB, WDATA_LSB, RMEM_LSB).
- One sub-module, trace_ram: DEPTH × TRACE_W register array with one synchronous write port (we, waddr, wdata) and one combinational read port (raddr, rdata). It has no reset.
- FSM, pointers, counters and trigger compare live in trace_capture_buffer.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release → state=0, count=0, rd_valid=0, triggered=0. Toggling the debug bus without arm leaves count=0.
- Basic trigger: arm, drive instruction=k for k=0,1,2…; trig_mask=FFFFFFFF, trig_value=5; POST_TRIG=8.
  - Required: DUMP reached with count=14 and triggered=1.
  - Readout with rd_ready=1 gives instructions 0..13 in order; rd_last on 13; back to IDLE.
- Wrap: same setup, trig_value=30 → count=16. Readout gives instructions 23..38; rd_last only on 38.
- Backpressure: during the basic-trigger dump, drive rd_ready in a 1-0-0-1 pattern → rd_data is stable while stalled, no entry is lost or duplicated, and exactly 14 handshakes occur.
- Immediate trigger: trig_mask=0, POST_TRIG=8 → triggers on the first armed cycle; count=9; readout gives the 9 consecutive samples from the first armed cycle.
- Reset mid-operation: assert rst=0 for one cycle in POST, and separately after 3 dump handshakes → next cycle state=0, count=0, rd_valid=0. A subsequent arm and trigger produces a correct fresh capture.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the debug-trace capture buffer: FSM encoding and packed entry layout.
package trace_pkg;

   localparam int unsigned DATA_W_DFLT = 32;
   localparam int unsigned NUM_FIELDS  = 5;
   localparam int unsigned TRACE_W     = NUM_FIELDS * DATA_W_DFLT;

   // Field offsets inside a packed entry; instruction occupies the MSBs.
   localparam int unsigned INSTR_LSB = 4 * DATA_W_DFLT;
   localparam int unsigned ALUA_LSB  = 3 * DATA_W_DFLT;
   localparam int unsigned ALUB_LSB  = 2 * DATA_W_DFLT;
   localparam int unsigned WDATA_LSB = 1 * DATA_W_DFLT;
   localparam int unsigned RMEM_LSB  = 0;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StArmed = 2'd1,
      StPost  = 2'd2,
      StDump  = 2'd3
   } trace_state_e;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: register array, one synchronous write port, one combinational read port.
module trace_ram #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned WIDTH  = 160
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/trace_capture_buffer.sv
// Circular debug-trace capture with instruction-match trigger and oldest-first valid/ready dump.
module trace_capture_buffer
   import trace_pkg::*;
#(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned POST_TRIG = 8,
   parameter int unsigned DATA_W    = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       arm,
   input  logic [DATA_W-1:0]          trig_mask,
   input  logic [DATA_W-1:0]          trig_value,
   input  logic [DATA_W-1:0]          instruction,
   input  logic [DATA_W-1:0]          alu_a,
   input  logic [DATA_W-1:0]          alu_b,
   input  logic [DATA_W-1:0]          write_data,
   input  logic [DATA_W-1:0]          read_data_mem,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [NUM_FIELDS*DATA_W-1:0] rd_data,
   output logic                       rd_last,
   output logic [1:0]                 state,
   output logic [ADDR_W:0]            count,
   output logic                       triggered
);

   localparam int unsigned   TraceW    = NUM_FIELDS * DATA_W;
   localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   CountOne  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PostInit  = ADDR_W'(POST_TRIG);

   trace_state_e      state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W-1:0] post_q, post_d;
   logic              trig_q, trig_d;

   logic              hit;
   logic              capture;
   logic              handshake;
   logic [ADDR_W-1:0] rd_ptr;
   logic [TraceW-1:0] wdata;
   logic [TraceW-1:0] rdata;

   assign hit       = ((instruction & trig_mask) == (trig_value & trig_mask));
   assign capture   = (state_q == StArmed) || (state_q == StPost);
   // Write pointer is frozen during the dump, so draining count walks rd_ptr forward.
   assign rd_ptr    = wr_ptr_q - count_q[ADDR_W-1:0];
   assign wdata     = {instruction, alu_a, alu_b, write_data, read_data_mem};
   assign handshake = rd_valid & rd_ready;

   trace_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  (TraceW)
   ) u_ram (
      .clk   (clk),
      .we    (capture),
      .waddr (wr_ptr_q),
      .wdata (wdata),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   // Next-state logic: capture bookkeeping, trigger handling and dump draining.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      post_d   = post_q;
      trig_d   = trig_q;

      if (capture) begin
         wr_ptr_d = wr_ptr_q + PtrOne;
         if (count_q != FullCount) begin
            count_d = count_q + CountOne;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (arm) begin
               state_d  = StArmed;
               wr_ptr_d = '0;
               count_d  = '0;
               post_d   = '0;
               trig_d   = 1'b0;
            end
         end
         StArmed: begin
            if (hit) begin
               trig_d  = 1'b1;
               post_d  = PostInit;
               state_d = (POST_TRIG == 0) ? StDump : StPost;
            end
         end
         StPost: begin
            post_d = post_q - PtrOne;
            if (post_q == PtrOne) begin
               state_d = StDump;
            end
         end
         StDump: begin
            if (handshake) begin
               count_d = count_q - CountOne;
               if (rd_last) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         wr_ptr_q <= '0;
         count_q  <= '0;
         post_q   <= '0;
         trig_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         post_q   <= post_d;
         trig_q   <= trig_d;
      end
   end

   // Readout outputs; rd_data is forced to zero outside the dump.
   always_comb begin
      rd_valid = (state_q == StDump);
      rd_last  = rd_valid && (count_q == CountOne);
      rd_data  = rd_valid ? rdata : '0;
   end

   assign state     = state_q;
   assign count     = count_q;
   assign triggered = trig_q;

endmodule
